tpu_instr_fetch: RTL

Fetch sequencer for the scalar-unit thread program, sitting directly upstream of the instruction memory.
- Walks a PC from a start to an end address and issues one-cycle load requests to the instruction memory (registered read, data valid the cycle after the request).
- Buffers returned instructions in a 2-entry queue and presents them to decode with a valid/stall handshake.
- Supports branch redirect with flush.

---
 rtl/tpu_instr_fetch_pkg.sv | 28 ++
 rtl/tpu_fetch_buf.sv | 45 ++++
 rtl/tpu_instr_fetch.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tpu_instr_fetch_pkg.sv
// Shared types for the scalar-unit fetch path: instruction/address types,
// fetch FSM states and the fetch queue entry.
package pkg_tpu;

  localparam int SIZE_THREAD_MEM = 1024;
  localparam int T_ADDR_W        = $clog2(SIZE_THREAD_MEM);
  localparam int T_INSTR_W       = 32;

  typedef logic [T_ADDR_W-1:0]  t_address_t;
  typedef logic [T_INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    instr_t     instr;
    t_address_t pc;
  } fetch_entry_t;

  // Sequential PC step; wraps from the top of thread memory back to 0.
  function automatic t_address_t pc_next(input t_address_t pc);
    return pc + t_address_t'(1);
  endfunction

endpackage

// File: rtl/tpu_fetch_buf.sv
// Two-entry queue of {instruction, PC} between instruction memory and decode.
// Flush has priority over push and pop.
module tpu_fetch_buf
  import pkg_tpu::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  // NOTE: the storage is reset along with the pointers so the head reads as 0
  // out of reset; it is only two entries, so the cost of the reset net is trivial.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/tpu_instr_fetch.sv
// Fetch sequencer: walks the PC from start to end, issues single-cycle loads to
// the registered instruction memory, queues returns and supports branch redirect.
module tpu_instr_fetch
  import pkg_tpu::*;
#(
  parameter int ADDR_W    = 10,
  parameter int INSTR_W   = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               I_Start,
  input  logic [ADDR_W-1:0]  I_Start_Address,
  input  logic [ADDR_W-1:0]  I_End_Address,
  output logic               O_Busy,
  output logic               O_Done,
  output logic               O_Req_Ld,
  output logic [ADDR_W-1:0]  O_Ld_Address,
  input  logic [INSTR_W-1:0] I_Ld_Instr,
  output logic               O_Valid,
  output logic [INSTR_W-1:0] O_Instr,
  output logic [ADDR_W-1:0]  O_PC,
  input  logic               I_Stall,
  input  logic               I_Br_Taken,
  input  logic [ADDR_W-1:0]  I_Br_Target
);

  fetch_state_t state;
  t_address_t   pc;
  t_address_t   end_pc;
  t_address_t   ret_pc;
  logic         inflight;
  logic         kill;

  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t wr_entry;

  logic         br;
  logic         pop;
  logic         push;
  logic         issue;
  logic         drain_done;
  logic [2:0]   occupancy;

  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    br         = I_Br_Taken && (state != IDLE);
    pop        = O_Valid && !I_Stall;
    push       = inflight && !kill;
    // Occupancy counts the entry already committed by an in-flight load, so a
    // new issue never lands on a full queue.
    occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue      = (state == FETCH) && (occupancy < 3'd2) && !I_Br_Taken;
    drain_done = (state == DRAIN) && (count == 2'd0) && !inflight && !I_Br_Taken;
    wr_entry   = '{instr: I_Ld_Instr, pc: ret_pc};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= '0;
      end_pc   <= '0;
      ret_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= br && inflight;
      if (issue) ret_pc <= pc;

      case (state)
        IDLE: begin
          if (I_Start) begin
            pc     <= I_Start_Address;
            end_pc <= I_End_Address;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (br) begin
            pc <= I_Br_Target;
          end else if (issue) begin
            pc <= pc_next(pc);
            if (pc == end_pc) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (br) begin
            pc    <= I_Br_Target;
            state <= FETCH;
          end else if (drain_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tpu_fetch_buf u_buf (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (br),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  assign O_Req_Ld     = issue;
  assign O_Ld_Address = pc;
  assign O_Valid      = (count != 2'd0);
  assign O_Instr      = head.instr;
  assign O_PC         = head.pc;
  assign O_Done       = drain_done;
  assign O_Busy       = (state != IDLE) && !drain_done;

endmodule
